// File: rtl/jtcps1_obj_frame_pkg.sv
// rtl/jtcps1_obj_frame_pkg.sv - shared CPS1 object package: copy FSM states and base scaling
package jtcps1_obj_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_REQ   = 3'd1,
      ST_WAIT  = 3'd2,
      ST_STORE = 3'd3,
      ST_SWAP  = 3'd4
   } obj_frame_state_t;

   // obj_base counts in 128-word units of VRAM
   localparam int OBJ_BASE_SHIFT = 7;
   localparam int OBJ_BASE_W     = 10;
   localparam int VRAM_AW        = 17;

   function automatic logic [VRAM_AW-1:0] obj_vram_addr(
      input logic [OBJ_BASE_W-1:0] base,
      input logic [VRAM_AW-1:0]    cnt
   );
      return {base, {OBJ_BASE_SHIFT{1'b0}}} + cnt;
   endfunction

endpackage

// File: rtl/jtcps1_obj_frame_bank.sv
// rtl/jtcps1_obj_frame_bank.sv - simple dual-port table bank, one write port, registered read port
module jtcps1_obj_frame_bank #(
   parameter int AW = 10,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [2**AW];

   // Only the output register is reset; the array keeps its contents
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (rst) rdata <= '0;
      else     rdata <= mem[raddr];
   end

endmodule

// File: rtl/jtcps1_obj_frame.sv
// rtl/jtcps1_obj_frame.sv - double-buffered object table copied from VRAM once per frame
module jtcps1_obj_frame
   import jtcps1_obj_frame_pkg::*;
#(
   parameter int TW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [15:0]   obj_base,
   output logic [16:0]   vram_addr,
   output logic          vram_cs,
   input  logic [15:0]   vram_data,
   input  logic          vram_ok,
   input  logic [TW-1:0] frame_addr,
   output logic [15:0]   frame_data,
   output logic          frame_ok,
   output logic          busy
);

   obj_frame_state_t st, st_nx;

   logic                  sel;
   logic [TW-1:0]         cnt;
   logic [OBJ_BASE_W-1:0] base_l;
   logic                  wait_2nd;
   logic [15:0]           cap;
   logic [TW-1:0]         last_addr;
   logic                  swap_q;
   logic                  rd_valid;
   logic                  bank_we;
   logic [15:0]           rd0, rd1;
   logic                  capture;
   logic                  unused_base;

   assign unused_base = ^obj_base[15:OBJ_BASE_W];

   // ok may still reflect the previous address during the first WAIT cycle
   assign capture = wait_2nd && vram_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= ST_IDLE;
         sel       <= 1'b0;
         cnt       <= '0;
         base_l    <= '0;
         wait_2nd  <= 1'b0;
         cap       <= '0;
         last_addr <= '0;
         swap_q    <= 1'b0;
         rd_valid  <= 1'b0;
      end else begin
         st        <= st_nx;
         swap_q    <= (st == ST_SWAP);
         rd_valid  <= 1'b1;
         last_addr <= frame_addr;
         case (st)
            ST_IDLE: if (start) begin
               base_l <= obj_base[OBJ_BASE_W-1:0];
               cnt    <= '0;
            end
            ST_REQ:   wait_2nd <= 1'b0;
            ST_WAIT: begin
               wait_2nd <= 1'b1;
               if (capture) cap <= vram_data;
            end
            ST_STORE: if (cnt != '1) cnt <= cnt + 1'b1;
            ST_SWAP:  sel <= ~sel;
            default: ;
         endcase
      end
   end

   always_comb begin
      st_nx     = st;
      vram_cs   = 1'b0;
      vram_addr = '0;
      bank_we   = 1'b0;
      case (st)
         ST_IDLE: if (start) st_nx = ST_REQ;
         ST_REQ: begin
            vram_cs   = 1'b1;
            vram_addr = obj_vram_addr(base_l, {{(VRAM_AW-TW){1'b0}}, cnt});
            st_nx     = ST_WAIT;
         end
         ST_WAIT: begin
            vram_cs   = 1'b1;
            vram_addr = obj_vram_addr(base_l, {{(VRAM_AW-TW){1'b0}}, cnt});
            if (capture) st_nx = ST_STORE;
         end
         ST_STORE: begin
            bank_we = 1'b1;
            st_nx   = (cnt == '1) ? ST_SWAP : ST_REQ;
         end
         ST_SWAP: st_nx = ST_IDLE;
         default: st_nx = ST_IDLE;
      endcase
   end

   assign busy = (st != ST_IDLE);

   // sel names the read bank, so only the other one is ever written
   jtcps1_obj_frame_bank #(.AW(TW), .DW(16)) u_bank0 (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we & sel),
      .waddr (cnt),
      .wdata (cap),
      .raddr (frame_addr),
      .rdata (rd0)
   );

   jtcps1_obj_frame_bank #(.AW(TW), .DW(16)) u_bank1 (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we & ~sel),
      .waddr (cnt),
      .wdata (cap),
      .raddr (frame_addr),
      .rdata (rd1)
   );

   assign frame_data = sel ? rd1 : rd0;
   assign frame_ok   = rd_valid && !swap_q && (frame_addr == last_addr);

endmodule

// File: tb/tb_jtcps1_obj_frame.sv
// tb/tb_jtcps1_obj_frame.sv - directed bench for jtcps1_obj_frame with a latency-programmable VRAM model
module tb_jtcps1_obj_frame;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] obj_base;
   logic [16:0] vram_addr;
   logic        vram_cs;
   logic [15:0] vram_data;
   logic        vram_ok;
   logic [9:0]  frame_addr;
   logic [15:0] frame_data;
   logic        frame_ok;
   logic        busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [15:0] key;
   int          lat;
   bit          stale;
   int          reads, swaps, busy_cyc, seq_err, run, min_run, max_run, same;
   logic [16:0] exp_addr, first_addr, addr129, last_req, last_a, idx;
   logic        prev_cs, prev_busy;

   jtcps1_obj_frame #(.TW(10)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .obj_base   (obj_base),
      .vram_addr  (vram_addr),
      .vram_cs    (vram_cs),
      .vram_data  (vram_data),
      .vram_ok    (vram_ok),
      .frame_addr (frame_addr),
      .frame_data (frame_data),
      .frame_ok   (frame_ok),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock step; also acts as the VRAM responder and bus monitor
   task automatic tick();
      @(negedge clk);
      if (busy) busy_cyc++;
      if (prev_busy && !busy) swaps++;
      if (vram_cs) run++;
      if (vram_cs && !prev_cs) begin
         reads++;
         if (vram_addr !== exp_addr) seq_err++;
         if (reads == 1) first_addr = vram_addr;
         if (reads == 129) addr129 = vram_addr;
         last_req = vram_addr;
         exp_addr = vram_addr + 17'd1;
      end
      if (!vram_cs && prev_cs) begin
         if (run < min_run) min_run = run;
         if (run > max_run) max_run = run;
         run = 0;
      end
      if (vram_cs && prev_cs && vram_addr == last_a) same++;
      else same = 0;
      last_a    = vram_addr;
      idx       = vram_addr - {obj_base[9:0], 7'b0};
      vram_data = idx[15:0] ^ key;
      vram_ok   = stale ? 1'b1 : (vram_cs && same >= lat);
      prev_cs   = vram_cs;
      prev_busy = busy;
   endtask

   task automatic begin_copy(input logic [15:0] base, input logic [15:0] k, input int l, input bit st_mode);
      obj_base = base;
      key      = k;
      lat      = l;
      stale    = st_mode;
      reads = 0; swaps = 0; busy_cyc = 0; seq_err = 0;
      run = 0; min_run = 999; max_run = 0;
      exp_addr   = {base[9:0], 7'b0};
      first_addr = '0;
      addr129    = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic run_copy(input logic [15:0] base, input logic [15:0] k, input int l, input bit st_mode,
                           input bit extra, input bit chk_old, input logic [15:0] old_v);
      begin_copy(base, k, l, st_mode);
      for (int i = 0; i < 6000; i++) begin
         if (!busy) break;
         start = extra && (i == 100 || i == 2500);
         if (chk_old && i == 600) begin
            chk("mid_copy_data", {16'h0, frame_data}, {16'h0, old_v});
            chk("mid_copy_ok", {31'h0, frame_ok}, 32'd1);
         end
         tick();
      end
      start = 1'b0;
      chk("copy_done", {31'h0, busy}, 32'd0);
      chk("copy_reads", reads, 32'd1024);
      chk("copy_swaps", swaps, 32'd1);
      chk("copy_cycles", busy_cyc, 32'd4097);
      chk("copy_addr_seq", seq_err, 32'd0);
      chk("swap_ok_dip", {31'h0, frame_ok}, 32'd0);
      tick();
   endtask

   task automatic read_at(input string tag, input logic [9:0] a, input logic [15:0] exp);
      frame_addr = a;
      #1;
      chk({tag, "_ok_drop"}, {31'h0, frame_ok}, 32'd0);
      tick();
      chk({tag, "_data"}, {16'h0, frame_data}, {16'h0, exp});
      chk({tag, "_ok"}, {31'h0, frame_ok}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; obj_base = '0; frame_addr = 10'd5;
      vram_data = '0; vram_ok = 1'b0;
      key = '0; lat = 2; stale = 1'b0;
      prev_cs = 1'b0; prev_busy = 1'b0; same = 0; last_a = '0; last_req = '0;
      reads = 0; swaps = 0; busy_cyc = 0; seq_err = 0; run = 0; min_run = 999; max_run = 0;
      exp_addr = '0; first_addr = '0; addr129 = '0; idx = '0;
      tick();
      tick();
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_cs", {31'h0, vram_cs}, 32'd0);
      chk("rst_addr", {15'h0, vram_addr}, 32'd0);
      chk("rst_fdata", {16'h0, frame_data}, 32'd0);
      chk("rst_fok", {31'h0, frame_ok}, 32'd0);
      rst = 1'b0;
      tick();

      // full copy, base 3, ok after 2 cycles
      run_copy(16'h0003, 16'hA5A5, 2, 1'b0, 1'b0, 1'b0, 16'h0000);
      chk("c1_first_addr", {15'h0, first_addr}, 32'h00180);
      chk("c1_last_addr", {15'h0, last_req}, 32'h0057F);
      chk("c1_data5", {16'h0, frame_data}, 32'hA5A0);
      chk("c1_ok5", {31'h0, frame_ok}, 32'd1);
      read_at("c1_rd1023", 10'd1023, 16'hA65A);
      read_at("c1_rd5", 10'd5, 16'hA5A0);

      // second copy with ignored start pulses; old table visible until swap
      run_copy(16'h0003, 16'h1234, 2, 1'b0, 1'b1, 1'b1, 16'hA5A0);
      chk("c2_data5", {16'h0, frame_data}, 32'h1231);
      chk("c2_ok5", {31'h0, frame_ok}, 32'd1);

      // reset while cnt = 300
      begin_copy(16'h0003, 16'h7777, 2, 1'b0);
      for (int i = 0; i < 3000; i++) begin
         if (reads == 301) break;
         tick();
      end
      chk("rc_reached_300", reads, 32'd301);
      rst = 1'b1;
      tick();
      chk("rc_busy", {31'h0, busy}, 32'd0);
      chk("rc_cs", {31'h0, vram_cs}, 32'd0);
      chk("rc_addr", {15'h0, vram_addr}, 32'd0);
      chk("rc_fdata", {16'h0, frame_data}, 32'd0);
      chk("rc_fok", {31'h0, frame_ok}, 32'd0);
      rst = 1'b0;
      tick();
      tick();
      chk("rc_busy_after", {31'h0, busy}, 32'd0);
      chk("rc_old_data", {16'h0, frame_data}, 32'h1231);
      chk("rc_old_ok", {31'h0, frame_ok}, 32'd1);

      // vram_ok stuck high: every request still spans REQ plus two WAIT cycles
      run_copy(16'h0003, 16'h0F0F, 0, 1'b1, 1'b0, 1'b1, 16'h1231);
      chk("st_min_cs_run", min_run, 32'd3);
      chk("st_max_cs_run", max_run, 32'd3);
      chk("st_data5", {16'h0, frame_data}, 32'h0F0A);

      // base at top of VRAM wraps to address 0 after word 127
      run_copy(16'h03FF, 16'h3C3C, 2, 1'b0, 1'b0, 1'b1, 16'h0F0A);
      chk("wr_first_addr", {15'h0, first_addr}, 32'h1FF80);
      chk("wr_addr129", {15'h0, addr129}, 32'h00000);
      chk("wr_data5", {16'h0, frame_data}, 32'h3C39);
      read_at("wr_rd128", 10'd128, 16'h3CBC);
      read_at("wr_rd1023", 10'd1023, 16'h3FC3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
